// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: arbiter state encoding, read-tag constants, default bus widths.
package cpu_defs;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        ARB_RUN    = 2'd0,
        ARB_DRAIN  = 2'd1,
        ARB_HALTED = 2'd2
    } arb_state_t;

    // Read tags identify which requester a returning read belongs to.
    localparam logic TAG_IF = 1'b0;
    localparam logic TAG_DM = 1'b1;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read tag pipe: LAT-deep shift register of {valid, tag} tracking outstanding memory reads.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears all entries)
//   i_valid, i_tag  entry pushed every cycle (valid=1 only for an issued read)
//   o_out_valid     entry at the pipe output is a read returning this cycle
//   o_out_tag       requester tag of the returning read
//   o_any_valid     a valid entry that will still be in flight after next cycle's return
module rd_tag_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    input  logic i_tag,
    output logic o_out_valid,
    output logic o_out_tag,
    output logic o_any_valid
);

    logic [LAT-1:0] r_valid;
    logic [LAT-1:0] r_tag;
    logic           w_any;

    // Shift one stage per cycle; stage LAT-1 lines up with mem_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_tag   <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_tag[0]   <= i_tag;
            for (int i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

    // Stages LAT-2 and LAT-1 will have left or be at the output next cycle,
    // so only stages below LAT-2 keep the pipe busy beyond that point.
    always_comb begin
        w_any = 1'b0;
        for (int i = 0; i < LAT - 2; i++) begin
            w_any = w_any | r_valid[i];
        end
    end

    assign o_out_valid = r_valid[LAT-1];
    assign o_out_tag   = r_tag[LAT-1];
    assign o_any_valid = w_any;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and data ports.
// One access per cycle, zero-latency grants, read data steered back by tag after LAT cycles,
// data-priority with a starvation limit for fetch, and a drain-then-halt sequence.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   if_req/if_addr                  fetch request; if_gnt/if_rvalid/if_rdata responses
//   dm_req/dm_we/dm_addr/dm_wdata   data request; dm_gnt/dm_rvalid/dm_rdata responses
//   stall                           some request lost arbitration this cycle
//   hlt/halted                      halt request in, drain-complete out
//   mem_*                           memory access port, mem_rdata valid LAT cycles after a read
module mem_arbiter
    import cpu_defs::*;
#(
    parameter int ADDR_W     = int'(DEF_ADDR_W),
    parameter int DATA_W     = int'(DEF_DATA_W),
    parameter int LAT        = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall,
    input  logic              hlt,
    output logic              halted,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned SW = $clog2(STARVE_LIM + 1);

    arb_state_t     r_state;
    logic [SW-1:0]  r_streak;
    logic           w_sel_if;
    logic           w_sel_dm;
    logic           w_push_valid;
    logic           w_push_tag;
    logic           w_out_valid;
    logic           w_out_tag;
    logic           w_busy;

    // Grant decision: data wins contention until fetch has waited STARVE_LIM data grants.
    // Gated by rst so every grant-derived output is low while reset is held.
    always_comb begin
        w_sel_if = 1'b0;
        w_sel_dm = 1'b0;
        if (!rst && r_state == ARB_RUN) begin
            if (if_req && dm_req) begin
                if (r_streak == SW'(STARVE_LIM)) w_sel_if = 1'b1;
                else                             w_sel_dm = 1'b1;
            end else begin
                w_sel_if = if_req;
                w_sel_dm = dm_req;
            end
        end
    end

    assign if_gnt    = w_sel_if;
    assign dm_gnt    = w_sel_dm;
    assign mem_en    = w_sel_if | w_sel_dm;
    assign mem_we    = w_sel_dm & dm_we;
    assign mem_addr  = w_sel_dm ? dm_addr : (w_sel_if ? if_addr : '0);
    assign mem_wdata = (w_sel_dm & dm_we) ? dm_wdata : '0;
    assign stall     = (if_req & ~w_sel_if) | (dm_req & ~w_sel_dm);

    assign w_push_valid = w_sel_if | (w_sel_dm & ~dm_we);
    assign w_push_tag   = w_sel_dm ? TAG_DM : TAG_IF;

    rd_tag_pipe #(
        .LAT (LAT)
    ) u_rd_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (w_push_valid),
        .i_tag       (w_push_tag),
        .o_out_valid (w_out_valid),
        .o_out_tag   (w_out_tag),
        .o_any_valid (w_busy)
    );

    // Returning read is steered by its tag; both rdata buses carry the memory data.
    assign if_rvalid = w_out_valid & (w_out_tag == TAG_IF);
    assign dm_rvalid = w_out_valid & (w_out_tag == TAG_DM);
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign halted    = (r_state == ARB_HALTED);

    // Control FSM plus fetch-starvation counter.
    // DRAIN exits once no read remains beyond the one returning next cycle, so halted
    // coincides with the final rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ARB_RUN;
            r_streak <= '0;
        end else begin
            case (r_state)
                ARB_RUN:    if (hlt) r_state <= ARB_DRAIN;
                ARB_DRAIN:  if (!w_busy) r_state <= ARB_HALTED;
                ARB_HALTED: r_state <= ARB_HALTED;
                default:    r_state <= ARB_RUN;
            endcase

            if (!if_req || w_sel_if) begin
                r_streak <= '0;
            end else if (w_sel_dm && r_streak != SW'(STARVE_LIM)) begin
                r_streak <= r_streak + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LAT=1,2,3) share stimulus; a cycle-level
// reference model (grant rules, queue of issued reads, halt arithmetic) predicts outputs.
module tb_mem_arbiter;

    localparam int NI = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 if_req, dm_req, dm_we, hlt;
    logic [15:0]          if_addr, dm_addr, dm_wdata;
    logic [NI-1:0]        if_gnt, if_rvalid, dm_gnt, dm_rvalid, stall, halted, mem_en, mem_we;
    logic [NI-1:0][15:0]  if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0]          env_mem [256];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory environment: writes taken from instance 0 (all instances see identical grants).
    always @(posedge clk) begin
        if (mem_en[0] && mem_we[0]) env_mem[mem_addr[0][7:0]] <= mem_wdata[0];
    end

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic [15:0] rp [4];
        always @(posedge clk) begin
            rp[0] <= env_mem[mem_addr[g][7:0]];
            for (int i = 1; i < 4; i++) rp[i] <= rp[i-1];
        end
        assign mem_rdata[g] = rp[g];

        mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LAT(g + 1), .STARVE_LIM(4)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
            .dm_gnt(dm_gnt[g]), .dm_rvalid(dm_rvalid[g]), .dm_rdata(dm_rdata[g]),
            .stall(stall[g]), .hlt(hlt), .halted(halted[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );
    end

    // ---------------- reference model ----------------
    typedef struct {int gc; logic tag; logic [15:0] data;} rd_t;
    rd_t         rq[$];
    logic [15:0] mmem [256];
    int          cyc = 0;
    int          streak = 0;
    bit          running = 1'b1;
    int          last_read = -100;
    int          halt_at [NI];

    logic        e_if_gnt, e_dm_gnt, e_mem_en, e_mem_we, e_stall;
    logic [15:0] e_mem_addr, e_mem_wdata;
    logic        e_if_rv [NI];
    logic        e_dm_rv [NI];
    logic        e_halted [NI];
    logic [15:0] e_rdata [NI];

    task automatic eval_cycle();
        @(negedge clk);
        e_if_gnt = 1'b0;
        e_dm_gnt = 1'b0;
        if (!rst && running) begin
            if (if_req && dm_req) begin
                if (streak >= 4) e_if_gnt = 1'b1;
                else             e_dm_gnt = 1'b1;
            end else begin
                e_if_gnt = if_req;
                e_dm_gnt = dm_req;
            end
        end
        e_mem_en    = e_if_gnt | e_dm_gnt;
        e_mem_we    = e_dm_gnt & dm_we;
        e_mem_addr  = e_dm_gnt ? dm_addr : (e_if_gnt ? if_addr : 16'h0);
        e_mem_wdata = e_mem_we ? dm_wdata : 16'h0;
        e_stall     = (if_req & ~e_if_gnt) | (dm_req & ~e_dm_gnt);
        for (int g = 0; g < NI; g++) begin
            e_if_rv[g]  = 1'b0;
            e_dm_rv[g]  = 1'b0;
            e_rdata[g]  = 16'h0;
            e_halted[g] = !rst && (cyc >= halt_at[g]);
            if (!rst) begin
                foreach (rq[k]) begin
                    if (rq[k].gc + g + 1 == cyc) begin
                        e_if_rv[g] = !rq[k].tag;
                        e_dm_rv[g] = rq[k].tag;
                        e_rdata[g] = rq[k].data;
                    end
                end
            end
        end
    endtask

    task automatic end_cycle();
        if (rst) begin
            rq.delete();
            streak    = 0;
            running   = 1'b1;
            last_read = -100;
            for (int g = 0; g < NI; g++) halt_at[g] = 1 << 30;
        end else begin
            if (e_mem_en && !e_mem_we) begin
                rq.push_back('{cyc, e_dm_gnt, mmem[e_mem_addr[7:0]]});
                last_read = cyc;
            end
            if (e_mem_we) mmem[e_mem_addr[7:0]] = e_mem_wdata;
            if (!if_req || e_if_gnt) streak = 0;
            else if (e_dm_gnt && streak < 4) streak++;
            if (running && hlt) begin
                running = 1'b0;
                for (int g = 0; g < NI; g++)
                    halt_at[g] = (cyc + 2 > last_read + g + 1) ? cyc + 2 : last_read + g + 1;
            end
            while (rq.size() > 0 && rq[0].gc < cyc - 5) void'(rq.pop_front());
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        for (int i = 0; i < n; i++) begin
            eval_cycle();
            end_cycle();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1; if_addr = 16'h1234; dm_addr = 16'h5678;
        eval_cycle();
        for (int g = 0; g < NI; g++) begin
            n_vec++;
            if ({if_gnt[g], dm_gnt[g], mem_en[g], mem_we[g], halted[g], if_rvalid[g], dm_rvalid[g]} !== 7'b0) begin
                n_err++;
                $display("FAIL reset_ctl[%0d]: got %b want 0000000", g,
                         {if_gnt[g], dm_gnt[g], mem_en[g], mem_we[g], halted[g], if_rvalid[g], dm_rvalid[g]});
            end
            n_vec++;
            if (mem_addr[g] !== 16'h0 || mem_wdata[g] !== 16'h0) begin
                n_err++;
                $display("FAIL reset_bus[%0d]: got addr %h wdata %h want 0 0", g, mem_addr[g], mem_wdata[g]);
            end
        end
        end_cycle();
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_lone_fetch();
        if_req = 1'b1; if_addr = 16'h0010; dm_req = 1'b0;
        eval_cycle();
        for (int g = 0; g < NI; g++) begin
            n_vec++;
            if (if_gnt[g] !== 1'b1 || mem_addr[g] !== 16'h0010 || mem_we[g] !== 1'b0) begin
                n_err++;
                $display("FAIL lone_gnt[%0d]: got gnt %b addr %h we %b want 1 0010 0", g, if_gnt[g], mem_addr[g], mem_we[g]);
            end
        end
        end_cycle();
        if_req = 1'b0;
        eval_cycle();
        n_vec++;
        if (if_rvalid[0] !== 1'b1 || if_rdata[0] !== mmem[8'h10]) begin
            n_err++;
            $display("FAIL lone_rdata: got rv %b data %h want 1 %h", if_rvalid[0], if_rdata[0], mmem[8'h10]);
        end
        n_vec++;
        if (if_rvalid[2] !== 1'b0) begin
            n_err++;
            $display("FAIL lone_early_rv: got %b want 0", if_rvalid[2]);
        end
        end_cycle();
        idle(4);
    endtask

    task automatic test_contention();
        logic [5:0] order;
        order = 6'b101111;  // bit k = 1 when data is granted in cycle k
        if_req = 1'b1; if_addr = 16'h0050; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0060;
        for (int k = 0; k < 6; k++) begin
            eval_cycle();
            for (int g = 0; g < NI; g++) begin
                n_vec++;
                if (dm_gnt[g] !== order[k] || if_gnt[g] !== !order[k] || stall[g] !== 1'b1) begin
                    n_err++;
                    $display("FAIL contend[%0d] k=%0d: got dm %b if %b stall %b want %b %b 1",
                             g, k, dm_gnt[g], if_gnt[g], stall[g], order[k], !order[k]);
                end
            end
            end_cycle();
        end
        idle(5);
    endtask

    task automatic test_write_read();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'hBEEF; if_req = 1'b0;
        eval_cycle();
        n_vec++;
        if (dm_gnt[1] !== 1'b1 || mem_we[1] !== 1'b1 || mem_wdata[1] !== 16'hBEEF) begin
            n_err++;
            $display("FAIL wr_issue: got gnt %b we %b wdata %h want 1 1 beef", dm_gnt[1], mem_we[1], mem_wdata[1]);
        end
        end_cycle();
        dm_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            eval_cycle();
            for (int g = 0; g < NI; g++) begin
                n_vec++;
                if (dm_rvalid[g] !== (k == g + 1) || if_rvalid[g] !== 1'b0) begin
                    n_err++;
                    $display("FAIL wr_rd_rv[%0d] k=%0d: got dm %b if %b want %b 0", g, k, dm_rvalid[g], if_rvalid[g], k == g + 1);
                end
                if (k == g + 1) begin
                    n_vec++;
                    if (dm_rdata[g] !== 16'hBEEF) begin
                        n_err++;
                        $display("FAIL wr_rd_data[%0d]: got %h want beef", g, dm_rdata[g]);
                    end
                end
            end
            end_cycle();
            dm_req = 1'b0;
        end
        idle(3);
    endtask

    task automatic test_interleave();
        logic [15:0] d [3];
        int          kk;
        for (int i = 0; i < 3; i++) d[i] = mmem[8'h20 + i];
        for (int c = 0; c < 7; c++) begin
            if_req = (c == 0 || c == 2); dm_req = (c == 1); dm_we = 1'b0;
            if_addr = 16'h0020 + 16'(c); dm_addr = 16'h0021;
            eval_cycle();
            for (int g = 0; g < NI; g++) begin
                kk = c - (g + 1);
                n_vec++;
                if (if_rvalid[g] !== (kk == 0 || kk == 2) || dm_rvalid[g] !== (kk == 1)) begin
                    n_err++;
                    $display("FAIL ilv_rv[%0d] c=%0d: got if %b dm %b want %b %b", g, c, if_rvalid[g], dm_rvalid[g],
                             kk == 0 || kk == 2, kk == 1);
                end
                if (kk >= 0 && kk < 3) begin
                    n_vec++;
                    if ((kk == 1 ? dm_rdata[g] : if_rdata[g]) !== d[kk]) begin
                        n_err++;
                        $display("FAIL ilv_data[%0d] c=%0d: got %h want %h", g, c, kk == 1 ? dm_rdata[g] : if_rdata[g], d[kk]);
                    end
                end
            end
            end_cycle();
        end
        idle(3);
    endtask

    task automatic test_random(input int n);
        bit keep_if, keep_dm;
        for (int i = 0; i < n; i++) begin
            eval_cycle();
            for (int g = 0; g < NI; g++) begin
                n_vec++;
                if ({if_gnt[g], dm_gnt[g], mem_en[g], mem_we[g], stall[g]} !==
                    {e_if_gnt, e_dm_gnt, e_mem_en, e_mem_we, e_stall}) begin
                    n_err++;
                    $display("FAIL rnd_ctl[%0d] cyc %0d: got %b want %b", g, cyc,
                             {if_gnt[g], dm_gnt[g], mem_en[g], mem_we[g], stall[g]},
                             {e_if_gnt, e_dm_gnt, e_mem_en, e_mem_we, e_stall});
                end
                if (e_mem_en) begin
                    n_vec++;
                    if (mem_addr[g] !== e_mem_addr || (e_mem_we && mem_wdata[g] !== e_mem_wdata)) begin
                        n_err++;
                        $display("FAIL rnd_bus[%0d] cyc %0d: got %h/%h want %h/%h", g, cyc,
                                 mem_addr[g], mem_wdata[g], e_mem_addr, e_mem_wdata);
                    end
                end
                n_vec++;
                if ({if_rvalid[g], dm_rvalid[g], halted[g]} !== {e_if_rv[g], e_dm_rv[g], e_halted[g]}) begin
                    n_err++;
                    $display("FAIL rnd_rv[%0d] cyc %0d: got %b want %b", g, cyc,
                             {if_rvalid[g], dm_rvalid[g], halted[g]}, {e_if_rv[g], e_dm_rv[g], e_halted[g]});
                end
                if (e_if_rv[g] || e_dm_rv[g]) begin
                    n_vec++;
                    if ((e_if_rv[g] ? if_rdata[g] : dm_rdata[g]) !== e_rdata[g]) begin
                        n_err++;
                        $display("FAIL rnd_data[%0d] cyc %0d: got %h want %h", g, cyc,
                                 e_if_rv[g] ? if_rdata[g] : dm_rdata[g], e_rdata[g]);
                    end
                end
            end
            keep_if = if_req && !e_if_gnt;
            keep_dm = dm_req && !e_dm_gnt;
            end_cycle();
            if (!keep_if) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 16'($urandom);
            end
            if (!keep_dm) begin
                dm_req   = ($urandom_range(0, 3) != 0);
                dm_we    = ($urandom_range(0, 2) == 0);
                dm_addr  = 16'($urandom);
                dm_wdata = 16'($urandom);
            end
        end
        idle(5);
    endtask

    task automatic test_halt();
        int hk;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0070; if_req = 1'b0; hlt = 1'b1;
        eval_cycle();
        for (int g = 0; g < NI; g++) begin
            n_vec++;
            if (dm_gnt[g] !== 1'b1 || halted[g] !== 1'b0) begin
                n_err++;
                $display("FAIL halt_gnt[%0d]: got gnt %b halted %b want 1 0", g, dm_gnt[g], halted[g]);
            end
        end
        end_cycle();
        if_req = 1'b1; if_addr = 16'h0071;
        for (int k = 1; k < 8; k++) begin
            if (k == 4) hlt = 1'b0;
            eval_cycle();
            for (int g = 0; g < NI; g++) begin
                hk = (g + 1 > 2) ? g + 1 : 2;
                n_vec++;
                if (if_gnt[g] !== 1'b0 || dm_gnt[g] !== 1'b0 || mem_en[g] !== 1'b0 || stall[g] !== 1'b1) begin
                    n_err++;
                    $display("FAIL halt_nogrant[%0d] k=%0d: got if %b dm %b en %b stall %b want 0 0 0 1",
                             g, k, if_gnt[g], dm_gnt[g], mem_en[g], stall[g]);
                end
                n_vec++;
                if (halted[g] !== (k >= hk) || dm_rvalid[g] !== (k == g + 1)) begin
                    n_err++;
                    $display("FAIL halt_seq[%0d] k=%0d: got halted %b rv %b want %b %b",
                             g, k, halted[g], dm_rvalid[g], k >= hk, k == g + 1);
                end
            end
            end_cycle();
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_reset_mid_read();
        if_req = 1'b1; if_addr = 16'h0030; dm_req = 1'b0;
        eval_cycle();
        n_vec++;
        if (if_gnt[2] !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_gnt: got %b want 1", if_gnt[2]);
        end
        end_cycle();
        rst = 1'b1;
        eval_cycle();
        for (int g = 0; g < NI; g++) begin
            n_vec++;
            if ({if_gnt[g], dm_gnt[g], mem_en[g], if_rvalid[g], dm_rvalid[g], halted[g]} !== 6'b0) begin
                n_err++;
                $display("FAIL rstmid_outs[%0d]: got %b want 000000", g,
                         {if_gnt[g], dm_gnt[g], mem_en[g], if_rvalid[g], dm_rvalid[g], halted[g]});
            end
        end
        end_cycle();
        rst = 1'b0; if_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            eval_cycle();
            for (int g = 0; g < NI; g++) begin
                n_vec++;
                if (if_rvalid[g] !== 1'b0 || dm_rvalid[g] !== 1'b0) begin
                    n_err++;
                    $display("FAIL rstmid_stale[%0d] k=%0d: got if %b dm %b want 0 0", g, k, if_rvalid[g], dm_rvalid[g]);
                end
            end
            end_cycle();
        end
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b1; hlt = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0;
        for (int g = 0; g < NI; g++) halt_at[g] = 1 << 30;
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            mmem[i] = v;
            env_mem[i] <= v;
        end
        test_reset();
        test_lone_fetch();
        test_contention();
        test_write_read();
        test_interleave();
        test_random(400);
        test_halt();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported unified instruction/data memory between the CPU's instruction-fetch port and its data-memory port. It issues at most one memory access per cycle and returns read data after a fixed latency, steered to the requester that issued the read. It stalls whichever requester loses arbitration and drains outstanding reads before reporting halt. It sits between `cpu` and the memory model, beside the PC and halt logic.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `LAT`, 1, memory read latency in cycles, legal 1..4
- `STARVE_LIM`, 4, maximum consecutive data grants while a fetch waits
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous reset, active-high
- `if_req`  in  1  fetch request, held until granted
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch issued to memory this cycle
- `if_rvalid`  out  1  fetch data valid
- `if_rdata`  out  DATA_W  fetch data
- `dm_req`  in  1  data request, held until granted
- `dm_we`  in  1  1 = write, 0 = read
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  write data
- `dm_gnt`  out  1  data access issued this cycle
- `dm_rvalid`  out  1  data read valid
- `dm_rdata`  out  DATA_W  data read data
- `stall`  out  1  `(if_req & ~if_gnt) | (dm_req & ~dm_gnt)`; holds PC and pipeline
- `hlt`  in  1  halt decoded by the CPU, level
- `halted`  out  1  drain complete, no access outstanding
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  valid exactly `LAT` cycles after a read strobe

## Operation
- States: RUN, DRAIN, HALTED. Reset enters RUN.
- RUN, grant decision is combinational within the cycle:
  - Only one request: grant it.
  - Both requests: grant data unless `streak == STARVE_LIM`, in which case grant fetch.
- `streak` (width `$clog2(STARVE_LIM+1)`): increments on a data grant while `if_req=1`. Clears on a fetch grant or on any cycle with `if_req=0`. Saturates at `STARVE_LIM`.
- On a grant: `mem_en=1`, and `mem_we`/`mem_addr`/`mem_wdata` come from the winner. A fetch always has `mem_we=0`.
- Reads push {valid=1, tag} into a `LAT`-deep tag pipe (tag 0 = fetch, 1 = data). Writes and idle cycles push valid=0.
- At the pipe output, pulse the tagged requester's `rvalid` for one cycle and drive its `rdata` from `mem_rdata`. The non-tagged `rdata` is undefined; the bench checks it only under `rvalid`.
- Writes get no `rvalid`. `dm_gnt` is the acceptance.
- RUN→DRAIN when `hlt=1` is sampled. In the cycle `hlt` first rises, the grant decision still uses RUN rules.
- DRAIN: no grants; `mem_en=0`. Go to HALTED when the tag pipe holds no valid entry.
- HALTED: `halted=1`, no grants. Only reset exits. `hlt` deasserting has no effect.

## Timing
- Reset values: all `gnt`/`rvalid`/`mem_en`/`mem_we`/`halted` = 0; `mem_addr`/`mem_wdata` = 0; `streak` = 0; tag pipe all invalid; state RUN.
- Grant latency is 0 cycles: `gnt` is in the same cycle as `req` when the requester wins.
- Read data: `rvalid` exactly `LAT` cycles after `gnt`.
- Throughput: one access per cycle, including back-to-back reads with a tag change each cycle.
- `halted` rises `LAT` cycles after the last read grant, or 1 cycle after entering DRAIN if nothing is outstanding.
- Reset mid-operation discards in-flight reads. No `rvalid` may fire after `rst` deasserts for reads issued before reset.
- `stall` is combinational from `req` and `gnt`, with no register.

## Structure
- The shared `cpu_defs` package/include holds:
  - state encodings `ARB_RUN=2'd0`, `ARB_DRAIN=2'd1`, `ARB_HALTED=2'd2`
  - tag constants `TAG_IF=1'b0`, `TAG_DM=1'b1`
  - default `ADDR_W`/`DATA_W`
- One sub-module, `rd_tag_pipe`: a `LAT`-deep shift register of {valid, tag} with async reset, exposing the output entry and an `any_valid` flag.

## Test plan
- Lone fetch, `LAT=1`: `if_req=1`, addr 0x0010 → `if_gnt=1` same cycle, `mem_addr=0x0010`; next cycle `if_rvalid=1`, `if_rdata` = mem value.
- Contention, `STARVE_LIM=4`: both requests held for 6 cycles → grant order D, D, D, D, I, D; `stall=1` on every cycle where a request is not granted.
- Data write then read, `LAT=2`: write 0xBEEF to 0x0040, then read 0x0040 → `dm_rvalid` 2 cycles after the read grant with 0xBEEF, and no `rvalid` for the write.
- Interleaved reads, `LAT=3`: fetch, data, fetch granted on cycles 0, 1, 2 → `if_rvalid` at 3, `dm_rvalid` at 4, `if_rvalid` at 5, with no misrouting.
- Halt drain, `LAT=2`: `hlt` rises in the same cycle as a data read grant → no grants afterward; `halted=1` 2 cycles later; requests then stay ungranted.
- Reset mid-read, `LAT=3`: assert `rst` 1 cycle after a fetch grant → all outputs 0 immediately; no `if_rvalid` after release.
